// File: rtl/pipeline_exec_ctrl.sv
// ============================================================================
// Module   : pipeline_exec_ctrl
// Brief    : Debug-unit execution controller: run/step/stop sequencing of the
//            MIPS pipeline stage enable, halt detection, enabled-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_exec_ctrl #(
  parameter int NB_CMD    = 2,
  parameter int NB_CYCLES = 32,
  parameter int NB_STATE  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [NB_CMD-1:0]    i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_halt_wb,
  input  logic                 i_cnt_clr,
  output logic                 o_dunit_clk_en,
  output logic                 o_done,
  output logic                 o_halted,
  output logic                 o_cmd_err,
  output logic [NB_STATE-1:0]  o_state,
  output logic [NB_CYCLES-1:0] o_cycle_cnt
);

  localparam logic [NB_CMD-1:0]    c_CMD_RUN  = NB_CMD'(1);
  localparam logic [NB_CMD-1:0]    c_CMD_STEP = NB_CMD'(2);
  localparam logic [NB_CMD-1:0]    c_CMD_STOP = NB_CMD'(3);
  localparam logic [NB_CYCLES-1:0] c_CNT_MAX  = {NB_CYCLES{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_done;
  logic                  r_err;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic                  w_accept;
  logic                  w_cmd_run_or_step;
  logic                  w_en;
  logic [NB_CYCLES-1:0]  r_cnt;

  // Enable and ready are decoded from registered state, but reset masks them
  // at once so a mid-run reset freezes the pipeline in the same cycle.
  assign w_en        = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !i_reset;
  assign o_cmd_ready = (r_state != ST_STEP) && !i_reset;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_cmd_run_or_step = (i_cmd == c_CMD_RUN) || (i_cmd == c_CMD_STEP);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_cmd == c_CMD_RUN))  w_state_nxt = ST_RUN;
        if (w_accept && (i_cmd == c_CMD_STEP)) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        // A retiring HALT takes priority and silently consumes any command.
        if (i_halt_wb) begin
          w_state_nxt = ST_HALTED;
          w_done_nxt  = 1'b1;
        end else if (w_accept && (i_cmd == c_CMD_STOP)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept && w_cmd_run_or_step) begin
          w_err_nxt = 1'b1;
        end
      end
      ST_STEP: begin
        w_state_nxt = i_halt_wb ? ST_HALTED : ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      ST_HALTED: begin
        if (w_accept && (i_cmd == c_CMD_STOP))      w_state_nxt = ST_IDLE;
        else if (w_accept && w_cmd_run_or_step)     w_err_nxt   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_en && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_dunit_clk_en = w_en;
  assign o_done         = r_done;
  assign o_cmd_err      = r_err;
  assign o_halted       = (r_state == ST_HALTED);
  assign o_state        = NB_STATE'(r_state);
  assign o_cycle_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_exec_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_exec_ctrl
// Brief    : Table-driven self-checking bench for pipeline_exec_ctrl, with a
//            second narrow-counter instance for saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_exec_ctrl;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STEP = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        halt_wb;
  logic        cnt_clr;
  logic        rdy, en, done, halted, err;
  logic [1:0]  st;
  logic [31:0] cnt;
  logic        rdy4, en4, done4, halted4, err4;
  logic [1:0]  st4;
  logic [3:0]  cnt4;

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_exec_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(rdy), .i_halt_wb(halt_wb), .i_cnt_clr(cnt_clr),
    .o_dunit_clk_en(en), .o_done(done), .o_halted(halted), .o_cmd_err(err),
    .o_state(st), .o_cycle_cnt(cnt)
  );

  pipeline_exec_ctrl #(.NB_CYCLES(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(rdy4), .i_halt_wb(halt_wb), .i_cnt_clr(cnt_clr),
    .o_dunit_clk_en(en4), .o_done(done4), .o_halted(halted4), .o_cmd_err(err4),
    .o_state(st4), .o_cycle_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  c;
    logic        h;
    logic        clr;
    logic        r;
    logic        en;
    logic        rdy;
    logic [1:0]  st;
    logic        done;
    logic        halted;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic v, input logic [1:0] c, input logic h,
                              input logic clr, input logic r, input logic e_en,
                              input logic e_rdy, input logic [1:0] e_st,
                              input logic e_done, input logic e_halted,
                              input logic e_err, input int e_cnt);
    vec_t t;
    t.v = v; t.c = c; t.h = h; t.clr = clr; t.r = r;
    t.en = e_en; t.rdy = e_rdy; t.st = e_st; t.done = e_done;
    t.halted = e_halted; t.err = e_err; t.cnt = 32'(e_cnt);
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic h,
                       input logic clr, input logic r);
    cmd_valid = v; cmd = c; halt_wb = h; cnt_clr = clr; rst = r;
  endtask

  initial begin
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b1);

    // Reset with a RUN held valid: must not be accepted.
    add(1, RUN,  0, 0, 1,  0, 0, 2'b00, 0, 0, 0, 0);
    add(1, RUN,  0, 0, 1,  0, 0, 2'b00, 0, 0, 0, 0);
    // Three single steps, each in its own idle window.
    for (int k = 0; k < 3; k++) begin
      add(1, STEP, 0, 0, 0,  0, 1, 2'b10, 0, 0, 0, k);
      add(0, NOP,  0, 0, 0,  1, 0, 2'b00, 1, 0, 0, k + 1);
    end
    add(0, NOP,  0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 3);
    add(1, STOP, 0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 3);
    add(0, NOP,  1, 0, 0,  0, 1, 2'b00, 0, 0, 0, 3);   // halt ignored in IDLE
    // RUN, STOP accepted on the 10th enabled cycle.
    add(0, NOP,  0, 1, 0,  0, 1, 2'b00, 0, 0, 0, 0);
    add(1, RUN,  0, 0, 0,  0, 1, 2'b01, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      add(0, NOP, 0, 0, 0,  1, 1, 2'b01, 0, 0, 0, k);
    add(1, STOP, 0, 0, 0,  1, 1, 2'b00, 0, 0, 0, 10);
    add(0, NOP,  0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 10);
    // RUN with HALT on the 7th enabled cycle.
    add(0, NOP,  0, 1, 0,  0, 1, 2'b00, 0, 0, 0, 0);
    add(1, RUN,  0, 0, 0,  0, 1, 2'b01, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      add(0, NOP, 0, 0, 0,  1, 1, 2'b01, 0, 0, 0, k);
    add(0, NOP,  1, 0, 0,  1, 1, 2'b11, 1, 1, 0, 7);
    add(0, NOP,  0, 0, 0,  0, 1, 2'b11, 0, 1, 0, 7);
    add(1, STEP, 0, 0, 0,  0, 1, 2'b11, 0, 1, 1, 7);
    add(0, NOP,  0, 0, 0,  0, 1, 2'b11, 0, 1, 0, 7);
    add(1, STOP, 0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 7);
    // STOP together with HALT in RUN: halt wins, no error.
    add(1, RUN,  0, 0, 0,  0, 1, 2'b01, 0, 0, 0, 7);
    add(0, NOP,  0, 0, 0,  1, 1, 2'b01, 0, 0, 0, 8);
    add(1, STOP, 1, 0, 0,  1, 1, 2'b11, 1, 1, 0, 9);
    add(0, NOP,  0, 0, 0,  0, 1, 2'b11, 0, 1, 0, 9);
    add(1, STOP, 0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 9);
    // Counter clear during an enabled cycle wins over increment.
    add(1, RUN,  0, 0, 0,  0, 1, 2'b01, 0, 0, 0, 9);
    add(0, NOP,  0, 0, 0,  1, 1, 2'b01, 0, 0, 0, 10);
    add(0, NOP,  0, 1, 0,  1, 1, 2'b01, 0, 0, 0, 0);
    add(0, NOP,  0, 0, 0,  1, 1, 2'b01, 0, 0, 0, 1);
    // Illegal RUN while running.
    add(1, RUN,  0, 0, 0,  1, 1, 2'b01, 0, 0, 1, 2);
    add(0, NOP,  0, 0, 0,  1, 1, 2'b01, 0, 0, 0, 3);
    add(1, STOP, 0, 0, 0,  1, 1, 2'b00, 0, 0, 0, 4);
    // One-cycle reset mid-RUN at count 5, command held valid.
    add(0, NOP,  0, 1, 0,  0, 1, 2'b00, 0, 0, 0, 0);
    add(1, RUN,  0, 0, 0,  0, 1, 2'b01, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, NOP, 0, 0, 0,  1, 1, 2'b01, 0, 0, 0, k);
    add(1, RUN,  0, 0, 1,  0, 0, 2'b00, 0, 0, 0, 0);
    add(0, NOP,  0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 0);
    // Reset mid-STEP: no done pulse.
    add(1, STEP, 0, 0, 0,  0, 1, 2'b10, 0, 0, 0, 0);
    add(0, NOP,  0, 0, 1,  0, 0, 2'b00, 0, 0, 0, 0);
    add(0, NOP,  0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 0);
    // STEP with HALT at write-back lands in HALTED.
    add(1, STEP, 0, 0, 0,  0, 1, 2'b10, 0, 0, 0, 0);
    add(0, NOP,  1, 0, 0,  1, 0, 2'b11, 1, 1, 0, 1);
    add(1, STOP, 0, 0, 0,  0, 1, 2'b00, 0, 0, 0, 1);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].c, vq[i].h, vq[i].clr, vq[i].r);
      #2;
      chk("clk_en", i, 32'(en), 32'(vq[i].en));
      chk("cmd_ready", i, 32'(rdy), 32'(vq[i].rdy));
      @(posedge clk); #1;
      chk("state", i, 32'(st), 32'(vq[i].st));
      chk("done", i, 32'(done), 32'(vq[i].done));
      chk("halted", i, 32'(halted), 32'(vq[i].halted));
      chk("cmd_err", i, 32'(err), 32'(vq[i].err));
      chk("cycle_cnt", i, cnt, vq[i].cnt);
    end

    // Saturation: the 4-bit counter instance must stick at 15.
    drive(1'b0, NOP, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("sat_clr", 0, 32'(cnt4), 32'd0);
    drive(1'b1, RUN, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("sat_cnt4", k, 32'(cnt4), (k > 15) ? 32'd15 : 32'(k));
      chk("sat_cnt32", k, cnt, 32'(k));
    end
    chk("sat_en4", 0, 32'(en4), 32'd1);
    drive(1'b1, STOP, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b0);
    chk("sat_state4", 0, 32'(st4), 32'd0);
    chk("sat_hold4", 0, 32'(cnt4), 32'd15);
    @(posedge clk); #1;
    chk("sat_done4", 0, 32'(done4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
